pmem_responder: RTL and testbench
=================================

# pmem_responder

Synthesizable responder for the cache-line physical-memory port driven by `mp3`. It accepts 128-bit line reads and writes on the `pmem_*` handshake and answers after a fixed, parameterized latency. It replaces the behavioural memory model when the core is built for FPGA or gate-level simulation, and it is the block that closes the `pmem_*` interface opposite the core's request side.

## Interface
- `LATENCY`, 4: edges from request acceptance to `pmem_resp` rising; legal range 1..255.
- `IDX_W`, 8: line-index width; storage holds 2^IDX_W lines of 128 bits.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `pmem_read`  in  1  line read request; held by the initiator until `pmem_resp`.
- `pmem_write`  in  1  line write request; held by the initiator until `pmem_resp`.
- `pmem_address`  in  16  byte address; line index = `pmem_address[IDX_W+3:4]`; bits [3:0] and bits above IDX_W+3 ignored, so addresses alias modulo 2^IDX_W lines.
- `pmem_wdata`  in  128  write line.
- `pmem_rdata`  out  128  read line; valid while `pmem_resp` is high.
- `pmem_resp`  out  1  one-cycle completion pulse.
- `pmem_err`  out  1  sticky protocol-violation flag.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: at an edge with exactly one of `pmem_read`/`pmem_write` high, latch the op, line index, and `pmem_wdata`; load the counter with LATENCY-1; go to BUSY. If both are high, set `pmem_err`, accept nothing, and stay in IDLE.
- BUSY: decrement the counter each edge. At the edge where the counter is 0 and the latched request line is still high:
  - a read loads `pmem_rdata` from storage;
  - a write stores the latched `wdata` into storage, and `pmem_rdata` is unchanged;
  - `pmem_resp` is set to 1 and the block goes to RESP.
- Abort: if the latched request line is low at any BUSY edge, go to IDLE with no response and no storage update.
- Changes on `pmem_address`, `pmem_wdata`, or the other request line during BUSY are ignored.
- RESP: clear `pmem_resp`; go to IDLE unconditionally. The request is still high at this edge, as seen by the block, and it is not re-accepted here.
- `pmem_err` is cleared only by reset.
- Storage contents are not reset and are retained across reset. Reading an unwritten line returns an undefined value.

## Timing
- Reset (`rst_n` low, asynchronous): state IDLE, `pmem_resp`=0, `pmem_rdata`=0, `pmem_err`=0, counter 0. Any in-flight operation is dropped and a pending write is not committed.
- Acceptance edge E0 leads to `pmem_resp` high from edge E0+LATENCY to edge E0+LATENCY+1, which is exactly one cycle.
- The write commits at E0+LATENCY. A read accepted later sees the new data.
- Back-to-back: the earliest next acceptance is E0+LATENCY+2. The initiator drops its request on the edge it samples `pmem_resp`; if it keeps the request high, that is a new request.
- LATENCY=1: BUSY lasts one edge, and `pmem_resp` rises at E0+1.
- All outputs are registered, with no combinational input-to-output path.

## Test plan
- Write then read, LATENCY=4: write 0x0123_4567_89AB_CDEF_0011_2233_4455_6677 to address 0x0040, accepted at E0 -> `pmem_resp` high only in cycle E0+4. Then read 0x004F, accepted at E1 -> `pmem_resp` at E1+4 with `pmem_rdata` equal to that line.
- Aliasing with IDX_W=8: write line A to 0x1040, then read 0x0040 -> returns A.
- Back-to-back with the request held: read held high through `pmem_resp` -> a second acceptance at E0+6, and a second `pmem_resp` at E0+10.
- Abort: write accepted at E0, `pmem_write` dropped at E0+2 -> no `pmem_resp`. A following read of the same line returns the previous contents.
- Protocol error: `pmem_read`=`pmem_write`=1 in IDLE -> `pmem_err`=1 from the next edge, no `pmem_resp`, and `pmem_err` stays 1 until `rst_n` is low.
- Reset mid-operation: `rst_n` low at E0+2 of a write -> `pmem_resp`, `pmem_rdata`, and `pmem_err` go to 0 immediately, and the line is not updated. After reset, a LATENCY=1 build reads with `pmem_resp` at E0+1.

Source files
------------

// File: rtl/pmem_responder.sv
// pmem_responder: fixed-latency cache-line memory behind the pmem_* port.
// Accepts one 128-bit line read or write, answers after LATENCY edges
// with a single-cycle pmem_resp pulse. Storage is not reset.
module pmem_responder #(
  parameter int LATENCY = 4,
  parameter int IDX_W   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         pmem_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int LINES = 1 << IDX_W;

  state_t             state;
  logic [7:0]         cnt;
  logic               op_wr;
  logic [IDX_W-1:0]   idx_q;
  logic [127:0]       wdata_q;
  logic [127:0]       mem [LINES];

  logic               req_held;
  logic               commit_wr;

  // The latched request line must stay high for the op to complete;
  // the other request line is ignored once an op is in flight.
  assign req_held  = op_wr ? pmem_write : pmem_read;
  assign commit_wr = (state == BUSY) && req_held && (cnt == 8'd0) && op_wr;

  // Address bits outside the line index only alias; fold them away.
  logic unused_addr;
  if (IDX_W + 4 < 16) begin : g_hi_unused
    assign unused_addr = ^{pmem_address[15:IDX_W+4], pmem_address[3:0]};
  end else begin : g_hi_used
    assign unused_addr = ^pmem_address[3:0];
  end

  // Control FSM with registered response, read data and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      op_wr      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      pmem_resp  <= 1'b0;
      pmem_rdata <= '0;
      pmem_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pmem_resp <= 1'b0;
          if (pmem_read && pmem_write) begin
            pmem_err <= 1'b1;
          end else if (pmem_read || pmem_write) begin
            op_wr   <= pmem_write;
            idx_q   <= pmem_address[IDX_W+3:4];
            wdata_q <= pmem_wdata;
            cnt     <= 8'(LATENCY - 1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (!req_held) begin
            state <= IDLE;
          end else if (cnt == 8'd0) begin
            if (!op_wr) pmem_rdata <= mem[idx_q];
            pmem_resp <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: begin
          // Request is still high here; it is a new request only next cycle.
          pmem_resp <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage: unreset so contents survive a reset; a write commits
  // only on its completion edge, so aborted or reset ops leave it intact.
  always_ff @(posedge clk) begin
    if (commit_wr) mem[idx_q] <= wdata_q;
  end

endmodule

// File: tb/tb_pmem_responder.sv
// Directed self-checking bench for pmem_responder (LATENCY=4 and LATENCY=1).
module tb_pmem_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rd, wr, rd1, wr1;
  logic [15:0]  addr, addr1;
  logic [127:0] wdata, wdata1;
  logic [127:0] rdata, rdata1;
  logic         resp, resp1, err, err1;

  int cmps = 0;
  int errs = 0;

  localparam logic [127:0] LA = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] LB = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] LC = 128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D;
  localparam logic [127:0] LD = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] LE = 128'hEEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE;
  localparam logic [127:0] LF = 128'h0F0F_0F0F_A5A5_A5A5_5A5A_5A5A_F0F0_F0F0;

  always #5 clk = ~clk;

  pmem_responder #(.LATENCY(4), .IDX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .pmem_read(rd), .pmem_write(wr),
    .pmem_address(addr), .pmem_wdata(wdata), .pmem_rdata(rdata),
    .pmem_resp(resp), .pmem_err(err)
  );

  pmem_responder #(.LATENCY(1), .IDX_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .pmem_read(rd1), .pmem_write(wr1),
    .pmem_address(addr1), .pmem_wdata(wdata1), .pmem_rdata(rdata1),
    .pmem_resp(resp1), .pmem_err(err1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction; resp must be low until E0+lat, high at
  // E0+lat with rdata == exp_rd, and low again one edge later.
  task automatic do_op(input bit which, input logic r, input logic w,
                       input logic [15:0] a, input logic [127:0] d,
                       input logic [127:0] exp_rd, input string tag);
    int lat;
    lat = which ? 1 : 4;
    if (which) begin rd1 = r; wr1 = w; addr1 = a; wdata1 = d; end
    else       begin rd  = r; wr  = w; addr  = a; wdata  = d; end
    tick();  // E0
    for (int i = 1; i < lat; i++) begin
      tick();
      chk({tag, "_resp_lo"}, which ? resp1 : resp, 1'b0);
    end
    tick();  // E0+lat
    chk({tag, "_resp_hi"}, which ? resp1 : resp, 1'b1);
    chk({tag, "_rdata"}, which ? rdata1 : rdata, exp_rd);
    if (which) begin rd1 = 1'b0; wr1 = 1'b0; end
    else       begin rd  = 1'b0; wr  = 1'b0; end
    tick();
    chk({tag, "_resp_end"}, which ? resp1 : resp, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    rd = 0; wr = 0; addr = '0; wdata = '0;
    rd1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;
    tick();
    chk("rst_resp", resp, 1'b0);
    chk("rst_rdata", rdata, '0);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;
    tick();

    // Write then read; write leaves rdata untouched.
    do_op(0, 0, 1, 16'h0040, LA, '0, "wr_A");
    do_op(0, 1, 0, 16'h004F, '0, LA, "rd_A");

    // Aliasing: 0x1040 and 0x0040 hit the same line.
    do_op(0, 0, 1, 16'h1040, LB, LA, "wr_B_alias");
    do_op(0, 1, 0, 16'h0040, '0, LB, "rd_B_alias");
    do_op(0, 0, 1, 16'h0050, LC, LB, "wr_C");
    do_op(0, 1, 0, 16'h0040, '0, LB, "rd_B_kept");
    do_op(0, 1, 0, 16'h0058, '0, LC, "rd_C");

    // Back-to-back: read held high through the response.
    rd = 1; addr = 16'h0040;
    tick();  // E0
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk($sformatf("b2b_resp_E%0d", e), resp, (e == 4 || e == 10) ? 1'b1 : 1'b0);
    end
    chk("b2b_rdata", rdata, LB);
    rd = 0;
    tick();
    chk("b2b_resp_end", resp, 1'b0);

    // Abort: write dropped before completion, line unchanged.
    wr = 1; addr = 16'h0040; wdata = LD;
    tick();  // E0
    tick();  // E0+1
    wr = 0;  // sampled low at E0+2
    for (int e = 2; e <= 6; e++) begin
      tick();
      chk($sformatf("abort_resp_E%0d", e), resp, 1'b0);
    end
    do_op(0, 1, 0, 16'h0040, '0, LB, "rd_after_abort");

    // Protocol error: both requests high in IDLE.
    rd = 1; wr = 1; addr = 16'h0050;
    tick();
    chk("perr_set", err, 1'b1);
    chk("perr_noresp", resp, 1'b0);
    rd = 0; wr = 0;
    for (int e = 0; e < 5; e++) begin
      tick();
      chk("perr_resp", resp, 1'b0);
    end
    chk("perr_sticky", err, 1'b1);
    do_op(0, 1, 0, 16'h0050, '0, LC, "rd_with_err");
    chk("perr_still", err, 1'b1);

    // Reset mid-write: outputs clear asynchronously, line not updated.
    wr = 1; addr = 16'h0040; wdata = LE;
    tick();  // E0
    tick();  // E0+1
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_resp", resp, 1'b0);
    chk("mrst_rdata", rdata, '0);
    chk("mrst_err", err, 1'b0);
    wr = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    do_op(0, 1, 0, 16'h0040, '0, LB, "rd_after_rst");
    chk("err_after_rst", err, 1'b0);

    // LATENCY=1 build after reset.
    chk("l1_rst_rdata", rdata1, '0);
    do_op(1, 0, 1, 16'h0010, LF, '0, "l1_wr_F");
    do_op(1, 1, 0, 16'h0010, '0, LF, "l1_rd_F");
    chk("l1_err", err1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
